// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream input and instruction-memory write port between the boot loader
// and its environment (UART RX on one side, fetch on the other).
interface boot_loader_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        skip_boot;
    logic [31:0] boot_addr;
    logic [31:0] boot_data;
    logic        debug;
    logic        core_hold;
    logic        done;
    logic        error;

    modport master (
        output rx_valid, rx_byte, skip_boot,
        input  boot_addr, boot_data, debug, core_hold, done, error
    );

    modport slave (
        input  rx_valid, rx_byte, skip_boot,
        output boot_addr, boot_data, debug, core_hold, done, error
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Parses a framed boot image from a byte stream, writes little-endian words into
// the instruction memory and releases the core once the checksum matches.
module boot_loader_ctrl #(
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter int unsigned MAX_WORDS = 8192,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    boot_loader_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          debug_q, debug_d;
    logic          in_frame;
    logic          last_word;

    assign in_frame  = (state_q inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK});
    // addr_q only advances after a strobe, so it is the index of the word being assembled
    assign last_word = (addr_q == (32'(count_q) - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            debug_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            debug_q    <= debug_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        timer_d    = '0;
        debug_d    = 1'b0;

        // The final word's strobe happens in CHECK, so the address never passes count-1
        if (debug_q && state_q == S_DATA) begin
            addr_d = addr_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.skip_boot) begin
                    state_d = S_DONE;
                end else if (bus.rx_valid && bus.rx_byte == MAGIC) begin
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (bus.rx_valid) begin
                    count_d = {8'h00, bus.rx_byte};
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (bus.rx_valid) begin
                    count_d = {bus.rx_byte, count_q[7:0]};
                    if (count_d == 16'd0) begin
                        state_d = S_CHECK;
                    end else if (32'(count_d) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    data_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_byte;
                    csum_d     = csum_q ^ bus.rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        debug_d = 1'b1;
                        if (last_word) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_byte == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
            end
        endcase

        // Idle watchdog between bytes of a frame; a byte arriving always rearms it
        if (in_frame && !bus.rx_valid) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = S_ERR;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign bus.boot_addr = addr_q;
    assign bus.boot_data = data_q;
    assign bus.debug     = debug_q;
    assign bus.core_hold = (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.error     = (state_q == S_ERR);
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: fixed frame vectors, corner-case
// sequences and randomized frames against an image-level reference model.
module tb_boot_loader_ctrl;
    localparam int TMO  = 64;
    localparam int MAXW = 8192;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boot_loader_ctrl_if bus();

    boot_loader_ctrl #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  b [12];
        int          n;
        int          nstb;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        done;
        logic        err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [63:0] strobes [$];

    // Every strobe seen by fetch, as {addr, data} sampled at the negedge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.debug === 1'b1) begin
            strobes.push_back({bus.boot_addr, bus.boot_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_strobes(input string name, input logic [63:0] exp_q [$]);
        chk({name, " strobe count"}, 32'(strobes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < strobes.size(); i++) begin
            chk($sformatf("%s strobe%0d addr", name, i), strobes[i][63:32], exp_q[i][63:32]);
            chk($sformatf("%s strobe%0d data", name, i), strobes[i][31:0], exp_q[i][31:0]);
        end
    endtask

    task automatic chk_status(input string name, input logic d, input logic e);
        chk({name, " done"}, 32'(bus.done), 32'(d));
        chk({name, " error"}, 32'(bus.error), 32'(e));
        chk({name, " core_hold"}, 32'(bus.core_hold), 32'(!d));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        idle(1);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.skip_boot = 1'b0;
        idle(2);
        rst_n = 1'b1;
        strobes.delete();
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        logic [63:0] exp_q [$];
        do_reset();
        for (int i = 0; i < v.n; i++) send(v.b[i]);
        idle(3);
        if (v.nstb > 0) exp_q.push_back({32'd0, v.w0});
        if (v.nstb > 1) exp_q.push_back({32'd1, v.w1});
        chk_strobes(name, exp_q);
        chk_status(name, v.done, v.err);
        $display("vector %s: bytes=%0d strobes=%0d done=%0b error=%0b",
                 name, v.n, strobes.size(), bus.done, bus.error);
    endtask

    // Random frame: expectation derived from how the image was built
    task automatic run_random(input int idx);
        logic [7:0]  frame [$];
        logic [63:0] exp_q [$];
        logic [31:0] w;
        logic [7:0]  cs;
        logic [7:0]  g;
        int          cnt;
        int          tpos;
        int          ngarb;
        bit          big;
        bit          bad;
        bit          tmo;
        bit          exp_done;
        bit          exp_err;

        do_reset();
        big  = ($urandom_range(0, 7) == 0);
        cnt  = big ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(0, 5));
        bad  = 1'b0;
        cs   = 8'h00;
        frame.push_back(8'hA5);
        frame.push_back(8'(cnt));
        frame.push_back(8'(cnt >> 8));
        if (big) begin
            frame.push_back(8'($urandom));
            frame.push_back(8'($urandom));
        end else begin
            for (int j = 0; j < cnt; j++) begin
                w = $urandom;
                for (int k = 0; k < 4; k++) begin
                    frame.push_back(w[8*k +: 8]);
                    cs ^= w[8*k +: 8];
                end
                exp_q.push_back({32'(j), w});
            end
            bad = ($urandom_range(0, 3) == 0);
            frame.push_back(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
        end
        tmo  = !big && ($urandom_range(0, 4) == 0);
        tpos = tmo ? int'($urandom_range(1, frame.size() - 1)) : -1;

        if (big) begin
            exp_q.delete();
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else if (tmo) begin
            // only words whose last byte (frame index 6+4j) precedes the stall get written
            while (exp_q.size() > 0 && 6 + 4 * (exp_q.size() - 1) >= tpos) void'(exp_q.pop_back());
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end else begin
            exp_done = !bad;
            exp_err  = bad;
        end

        ngarb = $urandom_range(0, 2);
        for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send(g);
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < frame.size(); i++) begin
            if (i == tpos) idle(TMO);
            else if (i > 0) idle($urandom_range(0, 2));
            if (i > 0) bus.skip_boot = 1'($urandom_range(0, 1));
            send(frame[i]);
        end
        bus.skip_boot = 1'b0;
        idle(3);
        chk_strobes($sformatf("rand%0d", idx), exp_q);
        chk_status($sformatf("rand%0d", idx), exp_done, exp_err);
        $display("random %0d: count=%0d bad_csum=%0b stall_at=%0d strobes=%0d done=%0b error=%0b",
                 idx, cnt, bad, tpos, strobes.size(), bus.done, bus.error);
    endtask

    vec_t vecs [8];

    initial begin
        logic [63:0] exp_q [$];

        vecs[0] = '{b: '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h60},
                    n: 12, nstb: 2, w0: 32'h13, w1: 32'h73, done: 1'b1, err: 1'b0};
        vecs[1] = '{b: '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h61},
                    n: 12, nstb: 2, w0: 32'h13, w1: 32'h73, done: 1'b0, err: 1'b1};
        vecs[2] = '{b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 4, nstb: 0, w0: 32'h0, w1: 32'h0, done: 1'b1, err: 1'b0};
        vecs[3] = '{b: '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 3, nstb: 0, w0: 32'h0, w1: 32'h0, done: 1'b0, err: 1'b1};
        vecs[4] = '{b: '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 6, nstb: 0, w0: 32'h0, w1: 32'h0, done: 1'b1, err: 1'b0};
        vecs[5] = '{b: '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 4, nstb: 0, w0: 32'h0, w1: 32'h0, done: 1'b0, err: 1'b1};
        vecs[6] = '{b: '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 8, nstb: 1, w0: 32'h04030201, w1: 32'h0, done: 1'b1, err: 1'b0};
        vecs[7] = '{b: '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
                    n: 8, nstb: 1, w0: 32'h04030201, w1: 32'h0, done: 1'b0, err: 1'b1};

        rst_n         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.skip_boot = 1'b0;
        #12;
        chk("reset boot_addr", bus.boot_addr, 32'h0);
        chk("reset boot_data", bus.boot_data, 32'h0);
        chk("reset debug", 32'(bus.debug), 32'h0);
        chk_status("reset", 1'b0, 1'b0);
        $display("reset: outputs checked while rst_n low");

        for (int i = 0; i < 8; i++) apply_vec($sformatf("v%0d", i), vecs[i]);

        // skip_boot beats a same-cycle MAGIC; the later frame is ignored
        do_reset();
        bus.skip_boot = 1'b1;
        send(8'hA5);
        bus.skip_boot = 1'b0;
        chk_status("skip", 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) send(vecs[0].b[i]);
        idle(2);
        exp_q.delete();
        chk_strobes("skip", exp_q);
        chk_status("skip after frame", 1'b1, 1'b0);
        $display("sequence skip_boot: done=%0b core_hold=%0b", bus.done, bus.core_hold);

        // watchdog boundary: one clock short is fine, exactly TMO idle clocks errors
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        idle(TMO - 1);
        chk("timeout early error", 32'(bus.error), 32'h0);
        idle(1);
        chk_status("timeout", 1'b0, 1'b1);
        send(8'h33); send(8'h44);
        idle(2);
        chk_strobes("timeout", exp_q);
        chk("timeout sticky", 32'(bus.error), 32'h1);
        $display("sequence timeout: error=%0b strobes=%0d", bus.error, strobes.size());

        // asynchronous reset mid-word, then a fresh frame from address 0
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        chk("partial word", bus.boot_data, 32'h00002211);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst boot_data", bus.boot_data, 32'h0);
        chk("async rst boot_addr", bus.boot_addr, 32'h0);
        chk_status("async rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) send(vecs[0].b[i]);
        idle(3);
        exp_q.delete();
        exp_q.push_back({32'd0, 32'h13});
        exp_q.push_back({32'd1, 32'h73});
        chk_strobes("after rst", exp_q);
        chk_status("after rst", 1'b1, 1'b0);
        $display("sequence mid-frame reset: strobes=%0d done=%0b", strobes.size(), bus.done);

        // a count of exactly MAX_WORDS is accepted
        do_reset();
        send(8'hA5); send(8'h00); send(8'h20);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(2);
        exp_q.delete();
        exp_q.push_back({32'd0, 32'hDEADBEEF});
        chk_strobes("maxwords", exp_q);
        chk_status("maxwords", 1'b0, 1'b0);
        $display("sequence max count: error=%0b strobes=%0d", bus.error, strobes.size());

        for (int i = 0; i < 40; i++) run_random(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
